// File: rtl/conversor_bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional macro BCD_7SEG_EN adds registered active-low 7-segment outputs HEX_DEZ/HEX_UNI.
module conversor_bin_bcd_seq #(
   parameter int WIDTH = 6
) (
   input  logic             CK,
   input  logic             CLR,
   input  logic             START,
   input  logic [WIDTH-1:0] BIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [3:0]       DEZ,
   output logic [3:0]       UNI
`ifdef BCD_7SEG_EN
   ,
   output logic [6:0]       HEX_DEZ,
   output logic [6:0]       HEX_UNI
`endif
);

   // Two BCD digits can hold at most 99; 6 bits (max 63) is the widest safe input.
   if (WIDTH < 1 || WIDTH > 6) begin : g_width_check
      $error("conversor_bin_bcd_seq: WIDTH must be in 1..6");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, FIM} state_t;

   localparam logic [2:0] CNT_INIT = 3'(WIDTH);

   state_t           state;
   state_t           next_state;
   logic             load;
   logic             shift_en;
   logic             finish;
   logic [WIDTH-1:0] sh;
   logic [3:0]       acc_d;
   logic [3:0]       acc_u;
   logic [3:0]       acc_d_adj;
   logic [3:0]       acc_u_adj;
   logic [2:0]       cnt;

`ifdef BCD_7SEG_EN
   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = 7'b1000000;
         4'd1:    code = 7'b1111001;
         4'd2:    code = 7'b0100100;
         4'd3:    code = 7'b0110000;
         4'd4:    code = 7'b0011001;
         4'd5:    code = 7'b0010010;
         4'd6:    code = 7'b0000010;
         4'd7:    code = 7'b1111000;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0010000;
         default: code = 7'b1111111;
      endcase
      return code;
   endfunction
`endif

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == 3'd1) next_state = FIM;
         end
         FIM: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Add-3 correction is applied to the pre-shift digits so the shift doubles them in BCD.
   assign acc_d_adj = (acc_d >= 4'd5) ? acc_d + 4'd3 : acc_d;
   assign acc_u_adj = (acc_u >= 4'd5) ? acc_u + 4'd3 : acc_u;

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         sh    <= '0;
         acc_d <= 4'd0;
         acc_u <= 4'd0;
         cnt   <= 3'd0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         DEZ   <= 4'd0;
         UNI   <= 4'd0;
`ifdef BCD_7SEG_EN
         HEX_DEZ <= 7'b1000000;
         HEX_UNI <= 7'b1000000;
`endif
      end else begin
         DONE <= 1'b0;
         if (load) begin
            sh    <= BIN;
            acc_d <= 4'd0;
            acc_u <= 4'd0;
            cnt   <= CNT_INIT;
            BUSY  <= 1'b1;
         end
         if (shift_en) begin
            {acc_d, acc_u, sh} <= {acc_d_adj, acc_u_adj, sh} << 1;
            cnt                <= cnt - 3'd1;
         end
         // Visible digits only change here, so intermediate accumulator values never leak out.
         if (finish) begin
            DEZ  <= acc_d;
            UNI  <= acc_u;
            DONE <= 1'b1;
            BUSY <= 1'b0;
`ifdef BCD_7SEG_EN
            HEX_DEZ <= seg7(acc_d);
            HEX_UNI <= seg7(acc_u);
`endif
         end
      end
   end

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Self-checking bench for conversor_bin_bcd_seq: vector table, handshake corner cases,
// counter-driven sweep of all values and randomized conversions against an arithmetic model.
module tb_conversor_bin_bcd_seq;

   localparam int W = 6;

   logic         CK;
   logic         CLR;
   logic         START;
   logic [W-1:0] BIN;
   logic         BUSY;
   logic         DONE;
   logic [3:0]   DEZ;
   logic [3:0]   UNI;
`ifdef BCD_7SEG_EN
   logic [6:0]   HEX_DEZ;
   logic [6:0]   HEX_UNI;
`endif

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   typedef struct {
      logic [W-1:0] bin;
      logic [3:0]   dez;
      logic [3:0]   uni;
   } vec_t;

   vec_t vecs [6];

   conversor_bin_bcd_seq #(.WIDTH(W)) dut (
      .CK     (CK),
      .CLR    (CLR),
      .START  (START),
      .BIN    (BIN),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .DEZ    (DEZ),
      .UNI    (UNI)
`ifdef BCD_7SEG_EN
      ,
      .HEX_DEZ(HEX_DEZ),
      .HEX_UNI(HEX_UNI)
`endif
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, req);
      end
   endtask

   task automatic check_digits(input string tag, input logic [3:0] exp_d, input logic [3:0] exp_u);
      check_output({tag, "_dez"}, 32'(DEZ), 32'(exp_d));
      check_output({tag, "_uni"}, 32'(UNI), 32'(exp_u));
`ifdef BCD_7SEG_EN
      check_output({tag, "_hex_dez"}, 32'(HEX_DEZ), 32'(seg_ref[exp_d]));
      check_output({tag, "_hex_uni"}, 32'(HEX_UNI), 32'(seg_ref[exp_u]));
`endif
   endtask

   // One complete conversion with latency, BUSY and hold-until-done checks.
   task automatic apply_stimulus(input logic [W-1:0] b, input logic [3:0] exp_d,
                                 input logic [3:0] exp_u, input string tag);
      logic [3:0] old_d;
      logic [3:0] old_u;
      int         lat;
      bit         held_ok;
      bit         busy_ok;
      @(negedge CK);
      old_d = DEZ;
      old_u = UNI;
      BIN   = b;
      START = 1'b1;
      @(negedge CK);
      START = 1'b0;
      BIN   = W'($urandom_range(0, (1 << W) - 1));
      check_output({tag, "_busy_rise"}, 32'(BUSY), 32'd1);
      lat     = 0;
      held_ok = 1'b1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge CK);
         if (DONE) lat = i;
         else begin
            if (DEZ !== old_d || UNI !== old_u) held_ok = 1'b0;
            if (BUSY !== 1'b1) busy_ok = 1'b0;
         end
      end
      check_output({tag, "_latency"}, 32'(lat), 32'(W + 1));
      check_output({tag, "_hold"}, 32'(held_ok), 32'd1);
      check_output({tag, "_busy_hold"}, 32'(busy_ok), 32'd1);
      check_output({tag, "_busy_fall"}, 32'(BUSY), 32'd0);
      check_digits(tag, exp_d, exp_u);
      @(negedge CK);
      check_output({tag, "_done_pulse"}, 32'(DONE), 32'd0);
   endtask

   initial begin
      int done_cnt;
      int ctr;
      int last_done;
      int cyc;
      int got;
      logic [W-1:0] rb;

      vecs[0] = '{bin: 6'd63, dez: 4'd6, uni: 4'd3};
      vecs[1] = '{bin: 6'd0,  dez: 4'd0, uni: 4'd0};
      vecs[2] = '{bin: 6'd9,  dez: 4'd0, uni: 4'd9};
      vecs[3] = '{bin: 6'd10, dez: 4'd1, uni: 4'd0};
      vecs[4] = '{bin: 6'd59, dez: 4'd5, uni: 4'd9};
      vecs[5] = '{bin: 6'd45, dez: 4'd4, uni: 4'd5};

      CLR   = 1'b1;
      START = 1'b0;
      BIN   = '0;
      #15 CLR = 1'b0;
      @(negedge CK);
      check_output("rst_busy", 32'(BUSY), 32'd0);
      check_output("rst_done", 32'(DONE), 32'd0);
      check_digits("rst", 4'd0, 4'd0);

      for (int v = 0; v < 6; v++)
         apply_stimulus(vecs[v].bin, vecs[v].dez, vecs[v].uni, $sformatf("vec%0d", v));

      // START while busy is ignored: a single DONE with the first value.
      @(negedge CK);
      BIN   = 6'd27;
      START = 1'b1;
      @(negedge CK);
      START = 1'b0;
      @(negedge CK);
      @(negedge CK);
      START = 1'b1;
      BIN   = 6'd1;
      @(negedge CK);
      START = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge CK);
         if (DONE) begin
            done_cnt++;
            check_digits("ignore_start", 4'd2, 4'd7);
         end
      end
      check_output("ignore_start_done_count", 32'(done_cnt), 32'd1);

      // CLR mid-conversion aborts at once and clears the previous result.
      @(negedge CK);
      BIN   = 6'd45;
      START = 1'b1;
      @(negedge CK);
      START = 1'b0;
      @(negedge CK);
      @(negedge CK);
      CLR = 1'b1;
      #1;
      check_output("abort_busy", 32'(BUSY), 32'd0);
      check_output("abort_done", 32'(DONE), 32'd0);
      check_digits("abort", 4'd0, 4'd0);
      @(negedge CK);
      CLR = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CK);
         if (DONE) done_cnt++;
      end
      check_output("abort_no_done", 32'(done_cnt), 32'd0);
      apply_stimulus(6'd45, 4'd4, 4'd5, "after_abort");

      // Down-counter sweep 63..0 with START held high; counter steps on each DONE.
      CLR = 1'b1;
      @(negedge CK);
      CLR = 1'b0;
      ctr       = 63;
      BIN       = W'(ctr);
      START     = 1'b1;
      done_cnt  = 0;
      last_done = -1;
      cyc       = 0;
      while (done_cnt < 64 && cyc < 64 * (W + 2) + 50) begin
         @(negedge CK);
         cyc++;
         if (DONE) begin
            got = int'(DEZ) * 10 + int'(UNI);
            check_output($sformatf("sweep_val%0d", ctr), 32'(got), 32'(ctr));
            if (last_done >= 0)
               check_output($sformatf("sweep_gap%0d", ctr), 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
            done_cnt++;
            ctr--;
            BIN = W'(ctr);
         end
      end
      START = 1'b0;
      check_output("sweep_done_count", 32'(done_cnt), 32'd64);
      repeat (W + 3) @(negedge CK);

      // Randomized conversions against plain decimal arithmetic.
      for (int r = 0; r < 40; r++) begin
         rb = W'($urandom_range(0, (1 << W) - 1));
         apply_stimulus(rb, 4'(int'(rb) / 10), 4'(int'(rb) % 10), $sformatf("rand%0d", r));
         repeat ($urandom_range(0, 3)) @(negedge CK);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
